func_unit: RTL and testbench
============================

FUNC_UNIT -- requirements
Module: func_unit

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high.
REQ-002 in_clk  input  1  clock; every register updates on its rising edge.
REQ-003 in_rst  input  1  reset, sampled on the rising edge of in_clk.
REQ-004 ALU issue inputs, all sampled only when in_rs_alu_start=1:
- in_rs_alu_start  1  ALU issue strobe
- in_rs_alu_fu_op  fu_op_t  operation
- in_rs_alu_val_a, in_rs_alu_val_b  GPR_SIZE each  operands
- in_rs_alu_dst_rob_index  ROB_IDX_SIZE  destination ROB tag
- in_rs_alu_set_nzcv  1  operation writes flags
- in_rs_alu_nzcv  nzcv_t  current flags
- in_rob_alu_cond_codes  cond_t  condition for conditional ops
REQ-005 LS issue inputs, all sampled only when in_rs_ls_start=1:
- in_rs_ls_start  1  LS issue strobe
- in_rs_ls_fu_op  fu_op_t  operation
- in_rs_ls_val_a  GPR_SIZE  base address
- in_rs_ls_val_b  GPR_SIZE  offset or store data (see REQ-013)
- in_rs_ls_dst_rob_index  ROB_IDX_SIZE  destination ROB tag
REQ-006 Ready outputs:
- out_rs_alu_ready  output  1  ALU can accept an issue this cycle
- out_rs_ls_ready  output  1  LS unit can accept an issue this cycle
REQ-007 Result bus outputs (single shared bus):
- out_rob_done  output  1  result valid
- out_rob_dst_rob_index  output  ROB_IDX_SIZE  result tag
- out_rob_value  output  GPR_SIZE  result value
- out_rob_set_nzcv  output  1  out_rob_nzcv is meaningful
- out_rob_nzcv  output  nzcv_t  resulting flags
- out_alu_condition  output  1  evaluated condition, for conditional ops and B.cond

Function
REQ-008 ALU latency: a start in cycle N produces its result on the bus in cycle N+1, registered; out_rob_done is high for exactly one cycle per instruction.
REQ-009 ALU ops, all modulo 2^GPR_SIZE:
- ADD: a+b
- SUB: a-b
- AND, ORR, EOR: bitwise
- MOV: b
- LSL, LSR, ASR: a shifted by b[5:0]
- CSEL: cond ? a : b
- CSINC: cond ? a : b+1
- CSINV: cond ? a : ~b
- CSNEG: cond ? a : -b
- BCOND: value 0, condition reported only
REQ-010 Condition evaluation: cond = ARM condition (EQ..AL, 4-bit) evaluated against in_rs_alu_nzcv; registered to out_alu_condition in the same cycle as the result.
REQ-011 Flags when set_nzcv=1:
- N = result[GPR_SIZE-1]; Z = (result==0)
- ADD: C = carry out; V = signed overflow
- SUB: C = NOT borrow (a>=b unsigned); V = signed overflow
- Logical ops: C=V=0
- out_rob_set_nzcv mirrors the issued set_nzcv; when it is 0, out_rob_nzcv passes in_rs_alu_nzcv through.
REQ-012 out_rs_alu_ready is 1 except in the cycle after reset assertion; the ALU accepts back-to-back issues.
REQ-013 LS unit: internal data memory of 256 x GPR_SIZE words, word index = address[10:3].
- LDUR: address = val_a + val_b; value = mem[address].
- STUR: address = val_a; mem[address] <= val_b; bus value 0.
- LS results carry set_nzcv=0.
REQ-014 LS latency: result is ready in cycle N+1 after a start in cycle N; out_rs_ls_ready drops to 0 from the start cycle +1 until that result has been driven on the bus.
REQ-015 Bus arbitration when ALU and LS results are ready in the same cycle:
- ALU result drives the bus.
- LS result is held in a pending register and driven the next cycle with no ALU result.
- out_rs_ls_ready stays 0 while LS is pending.
REQ-016 Protocol: a start while the corresponding ready=0 is a protocol violation; it is ignored (no result, no memory write).
REQ-017 Tag and value of each result come from the issuing instruction; no reordering within a unit.

Reset
REQ-018 While in_rst=1 at a clock edge, all of the following are 0:
- out_rob_done, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv, out_alu_condition
- LS pending flag
- ALU and LS in-flight operations are discarded.
REQ-019 Memory contents are zeroed on reset; out_rs_alu_ready=1 and out_rs_ls_ready=1 from the first cycle after reset deasserts.

Structure
REQ-020 Shared package holds:
- GPR_SIZE=64, ROB_IDX_SIZE=3, COND_SIZE=4
- fu_op_t enum, cond_t enum (ARM encoding), nzcv_t packed struct {n,z,c,v}
REQ-021 One sub-module, alu_cond_eval (combinational: cond_t + nzcv_t -> 1-bit); all else in func_unit.

Verification
REQ-022 ADD, set_nzcv=1, a=0x7FFFFFFFFFFFFFFF, b=1, tag 5 -> next cycle done=1, tag 5, value 0x8000000000000000, nzcv=1001.
REQ-023 SUB, set_nzcv=1, a=3, b=3 -> value 0, nzcv=0110; then CSEL EQ, a=10, b=20, nzcv=0100 -> value 10, out_alu_condition=1.
REQ-024 STUR val_a=0x10, val_b=0xDEAD, then LDUR val_a=0x8, val_b=0x8 -> second result value 0xDEAD; ls_ready low one cycle after each start.
REQ-025 ALU ADD 1+2 (tag 1) and LDUR (tag 2) issued same cycle -> cycle N+1: tag 1, value 3; cycle N+2: tag 2 load value; ls_ready 0 through N+2.
REQ-026 Reset asserted the cycle after an ALU start -> no done pulse; all outputs 0; both readys 1 after release.

Source files
------------

// File: rtl/func_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : func_unit_pkg
// Description : Shared widths, operation/condition encodings and flag struct
//               for the ALU + load/store functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
package func_unit_pkg;

    localparam int GPR_SIZE     = 64;
    localparam int ROB_IDX_SIZE = 3;
    localparam int COND_SIZE    = 4;
    localparam int SHAMT_SIZE   = 6;
    localparam int MEM_DEPTH    = 256;
    localparam int MEM_IDX_SIZE = $clog2(MEM_DEPTH);

    typedef enum logic [3:0] {
        FU_ADD   = 4'd0,
        FU_SUB   = 4'd1,
        FU_AND   = 4'd2,
        FU_ORR   = 4'd3,
        FU_EOR   = 4'd4,
        FU_MOV   = 4'd5,
        FU_LSL   = 4'd6,
        FU_LSR   = 4'd7,
        FU_ASR   = 4'd8,
        FU_CSEL  = 4'd9,
        FU_CSINC = 4'd10,
        FU_CSINV = 4'd11,
        FU_CSNEG = 4'd12,
        FU_BCOND = 4'd13,
        FU_LDUR  = 4'd14,
        FU_STUR  = 4'd15
    } fu_op_t;

    typedef enum logic [COND_SIZE-1:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage
`default_nettype wire

// File: rtl/func_unit_alu_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : alu_cond_eval
// Description : Combinational ARM condition-code evaluation against NZCV.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cond_eval
    import func_unit_pkg::*;
(
    input  cond_t i_cond,
    input  nzcv_t i_nzcv,
    output logic  o_holds
);

    always_comb begin
        o_holds = 1'b1;
        case (i_cond)
            COND_EQ: o_holds = i_nzcv.z;
            COND_NE: o_holds = ~i_nzcv.z;
            COND_CS: o_holds = i_nzcv.c;
            COND_CC: o_holds = ~i_nzcv.c;
            COND_MI: o_holds = i_nzcv.n;
            COND_PL: o_holds = ~i_nzcv.n;
            COND_VS: o_holds = i_nzcv.v;
            COND_VC: o_holds = ~i_nzcv.v;
            COND_HI: o_holds = i_nzcv.c & ~i_nzcv.z;
            COND_LS: o_holds = ~(i_nzcv.c & ~i_nzcv.z);
            COND_GE: o_holds = (i_nzcv.n == i_nzcv.v);
            COND_LT: o_holds = (i_nzcv.n != i_nzcv.v);
            COND_GT: o_holds = ~i_nzcv.z & (i_nzcv.n == i_nzcv.v);
            COND_LE: o_holds = i_nzcv.z | (i_nzcv.n != i_nzcv.v);
            // AL and NV both mean "always" in A64
            default: o_holds = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/func_unit.sv
`default_nettype none
// ============================================================================
// Module      : func_unit
// Description : Single-cycle ALU plus load/store unit with a private data
//               memory, sharing one registered result bus (ALU has priority).
// Revision    : 1.0 - initial release
// ============================================================================
module func_unit
    import func_unit_pkg::*;
(
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_rs_alu_start,
    input  fu_op_t                  in_rs_alu_fu_op,
    input  logic [GPR_SIZE-1:0]     in_rs_alu_val_a,
    input  logic [GPR_SIZE-1:0]     in_rs_alu_val_b,
    input  logic [ROB_IDX_SIZE-1:0] in_rs_alu_dst_rob_index,
    input  logic                    in_rs_alu_set_nzcv,
    input  nzcv_t                   in_rs_alu_nzcv,
    input  cond_t                   in_rob_alu_cond_codes,
    input  logic                    in_rs_ls_start,
    input  fu_op_t                  in_rs_ls_fu_op,
    input  logic [GPR_SIZE-1:0]     in_rs_ls_val_a,
    input  logic [GPR_SIZE-1:0]     in_rs_ls_val_b,
    input  logic [ROB_IDX_SIZE-1:0] in_rs_ls_dst_rob_index,
    output logic                    out_rs_alu_ready,
    output logic                    out_rs_ls_ready,
    output logic                    out_rob_done,
    output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic [GPR_SIZE-1:0]     out_rob_value,
    output logic                    out_rob_set_nzcv,
    output nzcv_t                   out_rob_nzcv,
    output logic                    out_alu_condition
);

    localparam int c_WORD_LSB = 3;
    localparam int c_WORD_MSB = c_WORD_LSB + MEM_IDX_SIZE - 1;

    logic                    r_alu_ready;
    logic                    r_ls_ready;
    logic                    r_pend_valid;
    logic [ROB_IDX_SIZE-1:0] r_pend_tag;
    logic [GPR_SIZE-1:0]     r_pend_value;
    logic [GPR_SIZE-1:0]     r_mem [MEM_DEPTH];

    logic                    w_alu_fire;
    logic                    w_ls_fire;
    logic                    w_cond;
    logic [SHAMT_SIZE-1:0]   w_shamt;
    logic [GPR_SIZE:0]       w_sum;
    logic [GPR_SIZE:0]       w_diff;
    logic [GPR_SIZE-1:0]     w_alu_value;
    logic                    w_flag_c;
    logic                    w_flag_v;
    nzcv_t                   w_alu_nzcv;
    logic                    w_is_load;
    logic                    w_is_store;
    logic [GPR_SIZE-1:0]     w_ls_addr;
    logic [MEM_IDX_SIZE-1:0] w_ls_idx;
    logic [GPR_SIZE-1:0]     w_ls_value;
    logic                    w_unused_ls_addr;

    // Ready registers read 0 while reset is held, so they also gate issue.
    assign out_rs_alu_ready = r_alu_ready;
    assign out_rs_ls_ready  = r_ls_ready;
    assign w_alu_fire       = in_rs_alu_start & r_alu_ready;
    assign w_ls_fire        = in_rs_ls_start & r_ls_ready;

    alu_cond_eval u_cond_eval (
        .i_cond  (in_rob_alu_cond_codes),
        .i_nzcv  (in_rs_alu_nzcv),
        .o_holds (w_cond)
    );

    assign w_shamt = in_rs_alu_val_b[SHAMT_SIZE-1:0];
    assign w_sum   = {1'b0, in_rs_alu_val_a} + {1'b0, in_rs_alu_val_b};
    assign w_diff  = {1'b0, in_rs_alu_val_a} - {1'b0, in_rs_alu_val_b};

    always_comb begin
        w_alu_value = '0;
        w_flag_c    = 1'b0;
        w_flag_v    = 1'b0;
        case (in_rs_alu_fu_op)
            FU_ADD: begin
                w_alu_value = w_sum[GPR_SIZE-1:0];
                w_flag_c    = w_sum[GPR_SIZE];
                w_flag_v    = (in_rs_alu_val_a[GPR_SIZE-1] == in_rs_alu_val_b[GPR_SIZE-1]) &&
                              (w_sum[GPR_SIZE-1] != in_rs_alu_val_a[GPR_SIZE-1]);
            end
            FU_SUB: begin
                // Top bit of the widened difference is the borrow.
                w_alu_value = w_diff[GPR_SIZE-1:0];
                w_flag_c    = ~w_diff[GPR_SIZE];
                w_flag_v    = (in_rs_alu_val_a[GPR_SIZE-1] != in_rs_alu_val_b[GPR_SIZE-1]) &&
                              (w_diff[GPR_SIZE-1] != in_rs_alu_val_a[GPR_SIZE-1]);
            end
            FU_AND:   w_alu_value = in_rs_alu_val_a & in_rs_alu_val_b;
            FU_ORR:   w_alu_value = in_rs_alu_val_a | in_rs_alu_val_b;
            FU_EOR:   w_alu_value = in_rs_alu_val_a ^ in_rs_alu_val_b;
            FU_MOV:   w_alu_value = in_rs_alu_val_b;
            FU_LSL:   w_alu_value = in_rs_alu_val_a << w_shamt;
            FU_LSR:   w_alu_value = in_rs_alu_val_a >> w_shamt;
            FU_ASR:   w_alu_value = $signed(in_rs_alu_val_a) >>> w_shamt;
            FU_CSEL:  w_alu_value = w_cond ? in_rs_alu_val_a : in_rs_alu_val_b;
            FU_CSINC: w_alu_value = w_cond ? in_rs_alu_val_a : in_rs_alu_val_b + GPR_SIZE'(1);
            FU_CSINV: w_alu_value = w_cond ? in_rs_alu_val_a : ~in_rs_alu_val_b;
            FU_CSNEG: w_alu_value = w_cond ? in_rs_alu_val_a : GPR_SIZE'(0) - in_rs_alu_val_b;
            default:  w_alu_value = '0;
        endcase
    end

    always_comb begin
        w_alu_nzcv = in_rs_alu_nzcv;
        if (in_rs_alu_set_nzcv) begin
            w_alu_nzcv.n = w_alu_value[GPR_SIZE-1];
            w_alu_nzcv.z = (w_alu_value == '0);
            w_alu_nzcv.c = w_flag_c;
            w_alu_nzcv.v = w_flag_v;
        end
    end

    assign w_is_load        = (in_rs_ls_fu_op == FU_LDUR);
    assign w_is_store       = (in_rs_ls_fu_op == FU_STUR);
    assign w_ls_addr        = w_is_load ? in_rs_ls_val_a + in_rs_ls_val_b : in_rs_ls_val_a;
    assign w_ls_idx         = w_ls_addr[c_WORD_MSB:c_WORD_LSB];
    assign w_ls_value       = w_is_load ? r_mem[w_ls_idx] : '0;
    assign w_unused_ls_addr = ^{w_ls_addr[GPR_SIZE-1:c_WORD_MSB+1], w_ls_addr[c_WORD_LSB-1:0]};

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_alu_ready           <= 1'b0;
            r_ls_ready            <= 1'b0;
            r_pend_valid          <= 1'b0;
            r_pend_tag            <= '0;
            r_pend_value          <= '0;
            out_rob_done          <= 1'b0;
            out_rob_dst_rob_index <= '0;
            out_rob_value         <= '0;
            out_rob_set_nzcv      <= 1'b0;
            out_rob_nzcv          <= '0;
            out_alu_condition     <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_alu_ready <= 1'b1;
            // LS stays busy through the cycle its result (direct or pending) is on the bus.
            r_ls_ready  <= ~w_ls_fire & ~r_pend_valid;

            if (w_ls_fire && w_is_store) begin
                r_mem[w_ls_idx] <= in_rs_ls_val_b;
            end

            if (w_alu_fire) begin
                out_rob_done          <= 1'b1;
                out_rob_dst_rob_index <= in_rs_alu_dst_rob_index;
                out_rob_value         <= w_alu_value;
                out_rob_set_nzcv      <= in_rs_alu_set_nzcv;
                out_rob_nzcv          <= w_alu_nzcv;
                out_alu_condition     <= w_cond;
            end else if (r_pend_valid) begin
                out_rob_done          <= 1'b1;
                out_rob_dst_rob_index <= r_pend_tag;
                out_rob_value         <= r_pend_value;
                out_rob_set_nzcv      <= 1'b0;
                out_rob_nzcv          <= '0;
                out_alu_condition     <= 1'b0;
            end else if (w_ls_fire) begin
                out_rob_done          <= 1'b1;
                out_rob_dst_rob_index <= in_rs_ls_dst_rob_index;
                out_rob_value         <= w_ls_value;
                out_rob_set_nzcv      <= 1'b0;
                out_rob_nzcv          <= '0;
                out_alu_condition     <= 1'b0;
            end else begin
                out_rob_done          <= 1'b0;
            end

            if (w_alu_fire && w_ls_fire) begin
                r_pend_valid <= 1'b1;
                r_pend_tag   <= in_rs_ls_dst_rob_index;
                r_pend_value <= w_ls_value;
            end else if (!w_alu_fire) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_func_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_func_unit
// Description : Self-checking bench for func_unit: directed vectors, a
//               behavioural result model and a per-cycle bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_func_unit;
    import func_unit_pkg::*;

    logic                    clk = 1'b0;
    logic                    in_rst;
    logic                    in_rs_alu_start;
    fu_op_t                  in_rs_alu_fu_op;
    logic [GPR_SIZE-1:0]     in_rs_alu_val_a;
    logic [GPR_SIZE-1:0]     in_rs_alu_val_b;
    logic [ROB_IDX_SIZE-1:0] in_rs_alu_dst_rob_index;
    logic                    in_rs_alu_set_nzcv;
    nzcv_t                   in_rs_alu_nzcv;
    cond_t                   in_rob_alu_cond_codes;
    logic                    in_rs_ls_start;
    fu_op_t                  in_rs_ls_fu_op;
    logic [GPR_SIZE-1:0]     in_rs_ls_val_a;
    logic [GPR_SIZE-1:0]     in_rs_ls_val_b;
    logic [ROB_IDX_SIZE-1:0] in_rs_ls_dst_rob_index;
    logic                    out_rs_alu_ready;
    logic                    out_rs_ls_ready;
    logic                    out_rob_done;
    logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index;
    logic [GPR_SIZE-1:0]     out_rob_value;
    logic                    out_rob_set_nzcv;
    nzcv_t                   out_rob_nzcv;
    logic                    out_alu_condition;

    always #5 clk = ~clk;

    func_unit dut (
        .in_clk                  (clk),
        .in_rst                  (in_rst),
        .in_rs_alu_start         (in_rs_alu_start),
        .in_rs_alu_fu_op         (in_rs_alu_fu_op),
        .in_rs_alu_val_a         (in_rs_alu_val_a),
        .in_rs_alu_val_b         (in_rs_alu_val_b),
        .in_rs_alu_dst_rob_index (in_rs_alu_dst_rob_index),
        .in_rs_alu_set_nzcv      (in_rs_alu_set_nzcv),
        .in_rs_alu_nzcv          (in_rs_alu_nzcv),
        .in_rob_alu_cond_codes   (in_rob_alu_cond_codes),
        .in_rs_ls_start          (in_rs_ls_start),
        .in_rs_ls_fu_op          (in_rs_ls_fu_op),
        .in_rs_ls_val_a          (in_rs_ls_val_a),
        .in_rs_ls_val_b          (in_rs_ls_val_b),
        .in_rs_ls_dst_rob_index  (in_rs_ls_dst_rob_index),
        .out_rs_alu_ready        (out_rs_alu_ready),
        .out_rs_ls_ready         (out_rs_ls_ready),
        .out_rob_done            (out_rob_done),
        .out_rob_dst_rob_index   (out_rob_dst_rob_index),
        .out_rob_value           (out_rob_value),
        .out_rob_set_nzcv        (out_rob_set_nzcv),
        .out_rob_nzcv            (out_rob_nzcv),
        .out_alu_condition       (out_alu_condition)
    );

    typedef struct {
        logic [ROB_IDX_SIZE-1:0] tag;
        logic [63:0]             val;
        logic                    set;
        logic [3:0]              nzcv;
        logic                    cond;
        int                      due;
    } exp_t;

    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    exp_t        alu_q[$];
    exp_t        ls_q[$];
    logic [63:0] mem_m [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ARM condition pseudocode: base test from cond[3:1], inverted by cond[0] except for 1111.
    function automatic bit cond_holds(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v, r;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c && !z;
            3'd5:    r = (n == v);
            3'd6:    r = (n == v) && !z;
            default: r = 1'b1;
        endcase
        if (cc[0] && cc != 4'hF) r = !r;
        return r;
    endfunction

    function automatic exp_t alu_model(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                                       input bit set, input logic [3:0] f, input logic [3:0] cc);
        exp_t        e;
        logic [63:0] r;
        longint      sa, sb, sr;
        bit          c, v, k;
        int          sh;
        c = 1'b0; v = 1'b0;
        k  = cond_holds(cc, f);
        sh = int'(b % 64);
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            FU_ADD:   r = a + b;
            FU_SUB:   r = a - b;
            FU_AND:   r = a & b;
            FU_ORR:   r = a | b;
            FU_EOR:   r = a ^ b;
            FU_MOV:   r = b;
            FU_LSL:   r = a << sh;
            FU_LSR:   r = a >> sh;
            FU_ASR:   r = $signed(a) >>> sh;
            FU_CSEL:  r = k ? a : b;
            FU_CSINC: r = k ? a : b + 64'd1;
            FU_CSINV: r = k ? a : ~b;
            FU_CSNEG: r = k ? a : 64'd0 - b;
            default:  r = 64'd0;
        endcase
        sr = $signed(r);
        if (op == FU_ADD) begin
            c = (r < a);
            v = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
        end else if (op == FU_SUB) begin
            c = (a >= b);
            v = (sa >= 0 && sb < 0 && sr < 0) || (sa < 0 && sb >= 0 && sr >= 0);
        end
        e.val  = r;
        e.set  = set;
        e.nzcv = set ? {r[63], (r == 64'd0), c, v} : f;
        e.cond = k;
        e.tag  = '0;
        e.due  = 0;
        return e;
    endfunction

    task automatic alu_issue(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                             input logic [2:0] tag, input bit set, input logic [3:0] f,
                             input logic [3:0] cc);
        exp_t e;
        in_rs_alu_start         = 1'b1;
        in_rs_alu_fu_op         = op;
        in_rs_alu_val_a         = a;
        in_rs_alu_val_b         = b;
        in_rs_alu_dst_rob_index = tag;
        in_rs_alu_set_nzcv      = set;
        in_rs_alu_nzcv          = nzcv_t'(f);
        in_rob_alu_cond_codes   = cond_t'(cc);
        e     = alu_model(op, a, b, set, f, cc);
        e.tag = tag;
        e.due = cyc + 1;
        alu_q.push_back(e);
    endtask

    task automatic ls_issue(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] tag, input bit accept);
        exp_t        e;
        logic [63:0] addr;
        int          idx;
        in_rs_ls_start         = 1'b1;
        in_rs_ls_fu_op         = op;
        in_rs_ls_val_a         = a;
        in_rs_ls_val_b         = b;
        in_rs_ls_dst_rob_index = tag;
        if (accept) begin
            addr   = (op == FU_LDUR) ? a + b : a;
            idx    = int'((addr / 8) % 256);
            e.val  = (op == FU_LDUR) ? mem_m[idx] : 64'd0;
            if (op == FU_STUR) mem_m[idx] = b;
            e.tag  = tag;
            e.set  = 1'b0;
            e.nzcv = 4'd0;
            e.cond = 1'b0;
            e.due  = cyc + 1;
            ls_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_rs_alu_start = 1'b0;
        in_rs_ls_start  = 1'b0;
    endtask

    // Bus monitor: an ALU result must appear exactly one cycle after issue;
    // any other done pulse must be the oldest outstanding LS result.
    always @(negedge clk) begin : p_mon
        exp_t e;
        if (mon_en) begin
            check("alu_ready", out_rs_alu_ready, 1);
            if (alu_q.size() > 0 && alu_q[0].due == cyc) begin
                e = alu_q.pop_front();
                check("alu_done", out_rob_done, 1);
                check("alu_tag", out_rob_dst_rob_index, e.tag);
                check("alu_value", out_rob_value, e.val);
                check("alu_set", out_rob_set_nzcv, e.set);
                check("alu_nzcv", out_rob_nzcv, e.nzcv);
                check("alu_cond", out_alu_condition, e.cond);
            end else if (out_rob_done) begin
                if (ls_q.size() > 0) begin
                    e = ls_q.pop_front();
                    check("ls_tag", out_rob_dst_rob_index, e.tag);
                    check("ls_value", out_rob_value, e.val);
                    check("ls_set", out_rob_set_nzcv, e.set);
                    check("ls_nzcv", out_rob_nzcv, e.nzcv);
                    check("ls_early", (cyc >= e.due), 1);
                end else begin
                    check("spurious_done", out_rob_done, 0);
                end
            end else if (ls_q.size() > 0 && cyc > ls_q[0].due + 3) begin
                e = ls_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL ls_timeout: tag %0d never reached the bus (due cycle %0d)", e.tag, e.due);
            end
        end
    end

    logic [63:0] a_tab [4];
    logic [63:0] b_tab [4];
    logic [3:0]  f_tab [4];

    initial begin
        exp_t e;
        foreach (mem_m[i]) mem_m[i] = 64'd0;
        a_tab = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd5};
        b_tab = '{64'h0F0F_0F0F_0F0F_0F0F, 64'd1, 64'h0000_0000_0000_0041, 64'd7};
        f_tab = '{4'b0000, 4'b0100, 4'b1001, 4'b0110};
        in_rst = 1'b1;
        in_rs_alu_start = 1'b0; in_rs_alu_fu_op = FU_ADD; in_rs_alu_val_a = '0; in_rs_alu_val_b = '0;
        in_rs_alu_dst_rob_index = '0; in_rs_alu_set_nzcv = 1'b0; in_rs_alu_nzcv = '0;
        in_rob_alu_cond_codes = COND_AL;
        in_rs_ls_start = 1'b0; in_rs_ls_fu_op = FU_LDUR; in_rs_ls_val_a = '0; in_rs_ls_val_b = '0;
        in_rs_ls_dst_rob_index = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_done", out_rob_done, 0);
        check("rst_tag", out_rob_dst_rob_index, 0);
        check("rst_value", out_rob_value, 0);
        check("rst_set", out_rob_set_nzcv, 0);
        check("rst_nzcv", out_rob_nzcv, 0);
        check("rst_cond", out_alu_condition, 0);
        in_rst = 1'b0;
        tick();
        check("post_rst_alu_ready", out_rs_alu_ready, 1);
        check("post_rst_ls_ready", out_rs_ls_ready, 1);
        mon_en = 1'b1;

        // Pin the model against hand-computed results
        e = alu_model(FU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'b0000, COND_AL);
        check("model_add_val", e.val, 64'h8000_0000_0000_0000);
        check("model_add_nzcv", e.nzcv, 4'b1001);
        e = alu_model(FU_SUB, 64'd3, 64'd3, 1'b1, 4'b0000, COND_AL);
        check("model_sub_nzcv", e.nzcv, 4'b0110);
        e = alu_model(FU_CSNEG, 64'd10, 64'd20, 1'b0, 4'b0100, COND_NE);
        check("model_csneg_val", e.val, 64'hFFFF_FFFF_FFFF_FFEC);
        check("model_csneg_cond", e.cond, 0);
        e = alu_model(FU_ASR, 64'h8000_0000_0000_0000, 64'd4, 1'b0, 4'b0000, COND_AL);
        check("model_asr_val", e.val, 64'hF800_0000_0000_0000);

        // Signed overflow on ADD
        alu_issue(FU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd5, 1'b1, 4'b0000, COND_AL);
        tick();
        check("add_done", out_rob_done, 1);
        check("add_tag", out_rob_dst_rob_index, 5);
        check("add_value", out_rob_value, 64'h8000_0000_0000_0000);
        check("add_nzcv", out_rob_nzcv, 4'b1001);

        // SUB to zero, then CSEL EQ back-to-back
        alu_issue(FU_SUB, 64'd3, 64'd3, 3'd0, 1'b1, 4'b0000, COND_AL);
        tick();
        check("sub_value", out_rob_value, 0);
        check("sub_nzcv", out_rob_nzcv, 4'b0110);
        alu_issue(FU_CSEL, 64'd10, 64'd20, 3'd1, 1'b0, 4'b0100, COND_EQ);
        tick();
        check("csel_value", out_rob_value, 10);
        check("csel_cond", out_alu_condition, 1);
        check("csel_nzcv_pass", out_rob_nzcv, 4'b0100);
        tick();
        check("idle_done", out_rob_done, 0);

        // Sweep of every ALU op with assorted operands, flags and conditions
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 14; i++) begin
                alu_issue(fu_op_t'(4'(i)), a_tab[(i + j) % 4], b_tab[(i + 2 * j) % 4], 3'(i),
                          ((i + j) % 2) == 1, f_tab[(i + 3 * j) % 4], 4'((i * 5 + j * 3) % 16));
                tick();
            end
        end
        tick();

        // Store then load through base+offset
        check("ls_ready_idle", out_rs_ls_ready, 1);
        ls_issue(FU_STUR, 64'h10, 64'hDEAD, 3'd3, 1'b1);
        tick();
        check("stur_ls_ready", out_rs_ls_ready, 0);
        check("stur_value", out_rob_value, 0);
        tick();
        check("stur_ls_ready_back", out_rs_ls_ready, 1);
        ls_issue(FU_LDUR, 64'h8, 64'h8, 3'd4, 1'b1);
        tick();
        check("ldur_value", out_rob_value, 64'hDEAD);
        check("ldur_ls_ready", out_rs_ls_ready, 0);
        tick();
        check("ldur_ls_ready_back", out_rs_ls_ready, 1);

        // Same-cycle ALU and LS results, plus an ignored store while busy
        alu_issue(FU_ADD, 64'd1, 64'd2, 3'd1, 1'b0, 4'b0000, COND_AL);
        ls_issue(FU_LDUR, 64'h8, 64'h8, 3'd2, 1'b1);
        tick();
        check("arb_n1_tag", out_rob_dst_rob_index, 1);
        check("arb_n1_value", out_rob_value, 3);
        check("arb_n1_ls_ready", out_rs_ls_ready, 0);
        ls_issue(FU_STUR, 64'h20, 64'hBAD, 3'd6, 1'b0);
        tick();
        check("arb_n2_done", out_rob_done, 1);
        check("arb_n2_tag", out_rob_dst_rob_index, 2);
        check("arb_n2_value", out_rob_value, 64'hDEAD);
        check("arb_n2_ls_ready", out_rs_ls_ready, 0);
        tick();
        check("arb_n3_ls_ready", out_rs_ls_ready, 1);
        check("arb_n3_done", out_rob_done, 0);

        // Pending LS result deferred by a second ALU issue
        alu_issue(FU_MOV, 64'd0, 64'h11, 3'd0, 1'b0, 4'b0000, COND_AL);
        ls_issue(FU_LDUR, 64'h20, 64'h0, 3'd7, 1'b1);
        tick();
        check("defer_n1_value", out_rob_value, 64'h11);
        alu_issue(FU_EOR, 64'hF0, 64'h0F, 3'd1, 1'b0, 4'b0000, COND_AL);
        tick();
        check("defer_n2_tag", out_rob_dst_rob_index, 1);
        check("defer_n2_ls_ready", out_rs_ls_ready, 0);
        tick();
        check("defer_n3_tag", out_rob_dst_rob_index, 7);
        check("defer_n3_value", out_rob_value, 0);
        check("defer_n3_ls_ready", out_rs_ls_ready, 0);
        tick();
        check("defer_n4_ls_ready", out_rs_ls_ready, 1);

        // Reset sampled together with an ALU start discards it
        mon_en = 1'b0;
        alu_issue(FU_ADD, 64'd5, 64'd5, 3'd3, 1'b1, 4'b0000, COND_AL);
        alu_q.delete();
        ls_q.delete();
        in_rst = 1'b1;
        tick();
        check("midrst_done", out_rob_done, 0);
        check("midrst_value", out_rob_value, 0);
        check("midrst_tag", out_rob_dst_rob_index, 0);
        check("midrst_nzcv", out_rob_nzcv, 0);
        in_rst = 1'b0;
        foreach (mem_m[i]) mem_m[i] = 64'd0;
        tick();
        check("midrst_post_done", out_rob_done, 0);
        check("midrst_alu_ready", out_rs_alu_ready, 1);
        check("midrst_ls_ready", out_rs_ls_ready, 1);
        mon_en = 1'b1;
        ls_issue(FU_LDUR, 64'h10, 64'h0, 3'd5, 1'b1);
        tick();
        check("mem_cleared", out_rob_value, 0);
        tick();
        alu_issue(FU_LSL, 64'd3, 64'd62, 3'd2, 1'b1, 4'b0000, COND_AL);
        tick();
        repeat (4) tick();

        check("alu_q_empty", alu_q.size(), 0);
        check("ls_q_empty", ls_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
